// File: rtl/multi_channel_producer_pkg.sv
// Shared definitions for the multi-channel request producer.
//   ADDRESS_WIDTH / ID_WIDTH : default per-channel address and id widths
//   FLUSH_CH_W               : width of the flush command channel field
//   prd_state_e              : per-channel issue FSM encoding
//   cnt_w()                  : width of a down/up counter that must hold n-1
package multi_channel_producer_pkg;

  localparam int ADDRESS_WIDTH = 16;
  localparam int ID_WIDTH      = 8;
  localparam int FLUSH_CH_W    = 4;

  typedef enum logic [1:0] {
    PRD_IDLE  = 2'd0,
    PRD_ISSUE = 2'd1,
    PRD_GAP   = 2'd2
  } prd_state_e;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_channel_producer_flush_fifo.sv
// flush_fifo: synchronous FIFO holding pending flush commands.
//   clk, reset : clock, async active-high reset (contents are dropped)
//   push, din  : write request and data; ignored while full
//   pop        : read request; ignored while empty
//   dout       : head entry, valid whenever empty=0 (show-ahead)
//   full/empty : occupancy flags
module flush_fifo
  import multi_channel_producer_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB tells a full queue apart from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/multi_channel_producer.sv
// multi_channel_producer: per-channel request generator with burst/gap pacing
// and a shared flush-command queue.
//   clk, reset          : clock, async active-high reset
//   ch_enable, in_stall : per-channel issue enable and backpressure
//   out_address/id/valid: per-channel request, channel c in slice c
//   flush_req/_ch/_id   : host push into the flush queue, flush_req_ready = not full
//   flush, flush_id     : one-cycle flush pulse and its id, slice of target channel
//
// state     | meaning
// PRD_IDLE  | channel disabled, valid low, counters kept
// PRD_ISSUE | request presented, waiting for accept
// PRD_GAP   | inter-burst idle, gap_cnt counting down to zero
module multi_channel_producer
  import multi_channel_producer_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = ADDRESS_WIDTH,
  parameter int ID_W        = ID_WIDTH,
  parameter int TAG_W       = 4,
  parameter int STRIDE      = 4,
  parameter int BURST_LEN   = 0,
  parameter int GAP_LEN     = 0,
  parameter int FLUSH_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      ch_enable,
  input  logic [NUM_CH-1:0]      in_stall,
  output logic [NUM_CH*ADDR_W-1:0] out_address,
  output logic [NUM_CH*ID_W-1:0] out_id,
  output logic [NUM_CH-1:0]      out_valid,
  input  logic                   flush_req,
  input  logic [FLUSH_CH_W-1:0]  flush_req_ch,
  input  logic [ID_W-1:0]        flush_req_id,
  output logic                   flush_req_ready,
  output logic [NUM_CH-1:0]      flush,
  output logic [NUM_CH*ID_W-1:0] flush_id
);

  localparam int SEQ_W   = ID_W - TAG_W;
  localparam int BEAT_W  = cnt_w(BURST_LEN);
  localparam int GAP_W   = cnt_w(GAP_LEN);
  localparam int ENTRY_W = FLUSH_CH_W + ID_W;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [TAG_W-1:0] TAG = TAG_W'(c + 1);

    prd_state_e        state;
    logic [ADDR_W-1:0] addr_q;
    logic [SEQ_W-1:0]  seq_q;
    logic [ID_W-1:0]   id_q;
    logic              valid_q;
    logic [BEAT_W-1:0] beat_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              accept;
    logic              burst_end;
    logic [ADDR_W-1:0] addr_next;
    logic [SEQ_W-1:0]  seq_next;

    assign accept    = valid_q && !in_stall[c];
    assign burst_end = (BURST_LEN != 0) && (beat_cnt == BEAT_W'(BURST_LEN - 1));
    // addr_q/seq_q hold the last loaded request, so the next one is one step ahead.
    assign addr_next = addr_q + ADDR_W'(STRIDE);
    assign seq_next  = seq_q + SEQ_W'(1);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state    <= PRD_IDLE;
        addr_q   <= '0;
        seq_q    <= '0;
        id_q     <= '0;
        valid_q  <= 1'b0;
        beat_cnt <= '0;
        gap_cnt  <= '0;
      end else begin
        case (state)
          PRD_IDLE: begin
            if (ch_enable[c]) begin
              addr_q  <= addr_next;
              seq_q   <= seq_next;
              id_q    <= {TAG, seq_next};
              valid_q <= 1'b1;
              state   <= PRD_ISSUE;
            end
          end
          PRD_ISSUE: begin
            if (accept) begin
              beat_cnt <= burst_end ? '0 : beat_cnt + BEAT_W'(1);
              if (!ch_enable[c]) begin
                valid_q <= 1'b0;
                state   <= PRD_IDLE;
              end else if (burst_end && (GAP_LEN != 0)) begin
                valid_q <= 1'b0;
                gap_cnt <= GAP_W'(GAP_LEN - 1);
                state   <= PRD_GAP;
              end else begin
                addr_q <= addr_next;
                seq_q  <= seq_next;
                id_q   <= {TAG, seq_next};
              end
            end
          end
          PRD_GAP: begin
            if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end else if (ch_enable[c]) begin
              addr_q  <= addr_next;
              seq_q   <= seq_next;
              id_q    <= {TAG, seq_next};
              valid_q <= 1'b1;
              state   <= PRD_ISSUE;
            end else begin
              state <= PRD_IDLE;
            end
          end
          default: begin
            valid_q <= 1'b0;
            state   <= PRD_IDLE;
          end
        endcase
      end
    end

    assign out_valid[c]                    = valid_q;
    assign out_address[c*ADDR_W +: ADDR_W] = addr_q;
    assign out_id[c*ID_W +: ID_W]          = id_q;
  end

  logic [ENTRY_W-1:0]    fifo_din;
  logic [ENTRY_W-1:0]    fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FLUSH_CH_W-1:0] pop_ch;
  logic [ID_W-1:0]       pop_id;

  assign fifo_din        = {flush_req_ch, flush_req_id};
  assign flush_req_ready = !fifo_full;
  assign pop_ch          = fifo_dout[ENTRY_W-1 -: FLUSH_CH_W];
  assign pop_id          = fifo_dout[ID_W-1:0];

  flush_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FLUSH_DEPTH)
  ) u_flush_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (flush_req),
    .pop   (!fifo_empty),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head entry is retired every cycle; an out-of-range channel just burns the slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush    <= '0;
      flush_id <= '0;
    end else begin
      flush    <= '0;
      flush_id <= '0;
      if (!fifo_empty) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (pop_ch == FLUSH_CH_W'(c)) begin
            flush[c]                <= 1'b1;
            flush_id[c*ID_W +: ID_W] <= pop_id;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_producer.sv
module tb_multi_channel_producer;

  localparam int NC = 2;
  localparam int AW = 16;
  localparam int IW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b1;
  logic [NC-1:0]   ch_enable = '0;
  logic [NC-1:0]   in_stall = '0;
  logic [NC-1:0]   en_b = '0;
  logic [NC-1:0]   stall_b = '0;
  logic            flush_req = 1'b0;
  logic [3:0]      flush_req_ch = '0;
  logic [IW-1:0]   flush_req_id = '0;

  logic [NC*AW-1:0] out_address, addr_b;
  logic [NC*IW-1:0] out_id, id_b;
  logic [NC-1:0]    out_valid, valid_b;
  logic             flush_req_ready, ready_b;
  logic [NC-1:0]    flush, flush_b;
  logic [NC*IW-1:0] flush_id, fid_b;

  int total = 0;
  int bad = 0;

  multi_channel_producer dut (
    .clk(clk), .reset(reset), .ch_enable(ch_enable), .in_stall(in_stall),
    .out_address(out_address), .out_id(out_id), .out_valid(out_valid),
    .flush_req(flush_req), .flush_req_ch(flush_req_ch), .flush_req_id(flush_req_id),
    .flush_req_ready(flush_req_ready), .flush(flush), .flush_id(flush_id)
  );

  multi_channel_producer #(.BURST_LEN(2), .GAP_LEN(3)) dut_b (
    .clk(clk), .reset(reset), .ch_enable(en_b), .in_stall(stall_b),
    .out_address(addr_b), .out_id(id_b), .out_valid(valid_b),
    .flush_req(flush_req), .flush_req_ch(flush_req_ch), .flush_req_id(flush_req_id),
    .flush_req_ready(ready_b), .flush(flush_b), .flush_id(fid_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k-th request of channel c (k counted from 1 after reset)
  function automatic logic [IW-1:0] ref_id(input int c, input int k);
    return IW'(((c + 1) << 4) | (k % 16));
  endfunction

  function automatic logic [AW-1:0] ref_addr(input int k);
    return AW'((k * 4) % 65536);
  endfunction

  task automatic test_reset();
    #12;
    total++;
    if (out_valid !== '0 || out_address !== '0 || out_id !== '0 || flush !== '0 || flush_id !== '0) begin
      bad++;
      $display("FAIL reset_outputs valid=%b addr=%h id=%h flush=%b fid=%h want all 0",
               out_valid, out_address, out_id, flush, flush_id);
    end
    total++;
    if (flush_req_ready !== 1'b1 || ready_b !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got %b/%b want 1/1", flush_req_ready, ready_b);
    end
    total++;
    if (valid_b !== '0 || addr_b !== '0 || id_b !== '0 || flush_b !== '0 || fid_b !== '0) begin
      bad++;
      $display("FAIL reset_outputs_b valid=%b addr=%h id=%h want all 0", valid_b, addr_b, id_b);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_issue();
    ch_enable = 2'b01;
    in_stall = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (out_valid !== 2'b01) begin
        bad++;
        $display("FAIL issue_valid k=%0d got %b want 01", k, out_valid);
      end
      total++;
      if (out_address[AW-1:0] !== ref_addr(k) || out_id[IW-1:0] !== ref_id(0, k)) begin
        bad++;
        $display("FAIL issue_req k=%0d got (%h,%h) want (%h,%h)", k,
                 out_address[AW-1:0], out_id[IW-1:0], ref_addr(k), ref_id(0, k));
      end
    end
  endtask

  task automatic test_stall();
    in_stall = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid[0] !== 1'b1 || out_address[AW-1:0] !== ref_addr(3) || out_id[IW-1:0] !== ref_id(0, 3)) begin
        bad++;
        $display("FAIL stall_hold i=%0d got v=%b (%h,%h) want v=1 (%h,%h)", i, out_valid[0],
                 out_address[AW-1:0], out_id[IW-1:0], ref_addr(3), ref_id(0, 3));
      end
    end
    in_stall = 2'b00;
    tick();
    total++;
    if (out_valid[0] !== 1'b1 || out_address[AW-1:0] !== ref_addr(4) || out_id[IW-1:0] !== ref_id(0, 4)) begin
      bad++;
      $display("FAIL stall_release got v=%b (%h,%h) want v=1 (%h,%h)", out_valid[0],
               out_address[AW-1:0], out_id[IW-1:0], ref_addr(4), ref_id(0, 4));
    end
    ch_enable = 2'b00;
    tick();
    total++;
    if (out_valid !== 2'b00) begin
      bad++;
      $display("FAIL disable_valid got %b want 00", out_valid);
    end
  endtask

  task automatic test_burst();
    int k = 0;
    logic exp_v;
    en_b = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_v = ((i % 5) < 2);
      if (exp_v) k++;
      total++;
      if (valid_b !== {1'b0, exp_v}) begin
        bad++;
        $display("FAIL burst_valid cyc=%0d got %b want %b", i, valid_b, {1'b0, exp_v});
      end
      if (exp_v) begin
        total++;
        if (addr_b[AW-1:0] !== ref_addr(k) || id_b[IW-1:0] !== ref_id(0, k)) begin
          bad++;
          $display("FAIL burst_req cyc=%0d got (%h,%h) want (%h,%h)", i,
                   addr_b[AW-1:0], id_b[IW-1:0], ref_addr(k), ref_id(0, k));
        end
      end
    end
    en_b = 2'b00;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_wrap();
    ch_enable = 2'b10;
    for (int t = 1; t <= 17; t++) begin
      tick();
      total++;
      if (out_valid !== 2'b10 || out_address[2*AW-1:AW] !== ref_addr(t) || out_id[2*IW-1:IW] !== ref_id(1, t)) begin
        bad++;
        $display("FAIL wrap_req t=%0d got v=%b (%h,%h) want v=10 (%h,%h)", t, out_valid,
                 out_address[2*AW-1:AW], out_id[2*IW-1:IW], ref_addr(t), ref_id(1, t));
      end
    end
    ch_enable = 2'b00;
    tick();
  endtask

  task automatic test_flush();
    logic [11:0]     q[$];
    logic [11:0]     popped;
    bit              have_pop;
    logic            exp_ready;
    logic [NC-1:0]   exp_flush;
    logic [NC*IW-1:0] exp_fid;
    int              pc;
    int              dir_ch[5];
    dir_ch = '{0, 1, 3, 0, 1};

    flush_req = 1'b1;
    flush_req_ch = 4'd0;
    flush_req_id = 8'h1a;
    tick();
    flush_req = 1'b0;
    total++;
    if (flush !== '0) begin
      bad++;
      $display("FAIL flush_early got %b want 00", flush);
    end
    tick();
    total++;
    if (flush !== 2'b01 || flush_id !== 16'h001a) begin
      bad++;
      $display("FAIL flush_pulse got %b/%h want 01/001a", flush, flush_id);
    end
    tick();
    total++;
    if (flush !== '0 || flush_id !== '0) begin
      bad++;
      $display("FAIL flush_one_cycle got %b/%h want 00/0000", flush, flush_id);
    end

    for (int cyc = 0; cyc < 50; cyc++) begin
      if (cyc < 5) begin
        flush_req = 1'b1;
        flush_req_ch = 4'(dir_ch[cyc]);
        flush_req_id = 8'(8'hA0 + cyc);
      end else if (cyc < 45) begin
        flush_req = 1'($urandom_range(0, 1));
        flush_req_ch = 4'($urandom_range(0, 3));
        flush_req_id = 8'($urandom);
      end else begin
        flush_req = 1'b0;
      end
      exp_ready = (q.size() < 4);
      #1;
      total++;
      if (flush_req_ready !== exp_ready) begin
        bad++;
        $display("FAIL flush_ready cyc=%0d got %b want %b", cyc, flush_req_ready, exp_ready);
      end
      have_pop = (q.size() > 0);
      if (have_pop) popped = q.pop_front();
      if (flush_req && exp_ready) q.push_back({flush_req_ch, flush_req_id});
      tick();
      exp_flush = '0;
      exp_fid = '0;
      if (have_pop) begin
        pc = int'(popped[11:8]);
        if (pc < NC) begin
          exp_flush[pc] = 1'b1;
          exp_fid[pc*IW +: IW] = popped[7:0];
        end
      end
      total++;
      if (flush !== exp_flush || flush_id !== exp_fid) begin
        bad++;
        $display("FAIL flush_seq cyc=%0d got %b/%h want %b/%h", cyc, flush, flush_id, exp_flush, exp_fid);
      end
    end
  endtask

  task automatic test_reset_mid();
    en_b = 2'b11;
    stall_b = 2'b00;
    tick();
    stall_b = 2'b11;
    tick();
    flush_req = 1'b1;
    flush_req_ch = 4'd1;
    flush_req_id = 8'h55;
    tick();
    flush_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++;
    if (valid_b !== '0 || addr_b !== '0 || id_b !== '0 || flush_b !== '0 || fid_b !== '0 || ready_b !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_b v=%b a=%h id=%h fl=%b rdy=%b want 0s rdy=1",
               valid_b, addr_b, id_b, flush_b, ready_b);
    end
    total++;
    if (out_valid !== '0 || out_address !== '0 || out_id !== '0 || flush !== '0 || flush_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid v=%b a=%h id=%h fl=%b rdy=%b want 0s rdy=1",
               out_valid, out_address, out_id, flush, flush_req_ready);
    end
    en_b = 2'b00;
    stall_b = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (flush !== '0 || flush_b !== '0) begin
      bad++;
      $display("FAIL reset_queue_lost got %b/%b want 00/00", flush, flush_b);
    end
    ch_enable = 2'b01;
    en_b = 2'b01;
    tick();
    total++;
    if (out_valid !== 2'b01 || out_address[AW-1:0] !== 16'h0004 || out_id[IW-1:0] !== 8'h11) begin
      bad++;
      $display("FAIL reset_first_req got v=%b (%h,%h) want v=01 (0004,11)",
               out_valid, out_address[AW-1:0], out_id[IW-1:0]);
    end
    total++;
    if (valid_b !== 2'b01 || addr_b[AW-1:0] !== 16'h0004 || id_b[IW-1:0] !== 8'h11) begin
      bad++;
      $display("FAIL reset_first_req_b got v=%b (%h,%h) want v=01 (0004,11)",
               valid_b, addr_b[AW-1:0], id_b[IW-1:0]);
    end
    ch_enable = 2'b00;
    en_b = 2'b00;
    tick();
  endtask

  task automatic test_random_traffic();
    int   n[NC];
    logic pv[NC];
    logic exp_v;
    ch_enable = '0;
    in_stall = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    for (int c = 0; c < NC; c++) begin
      n[c] = 0;
      pv[c] = 1'b0;
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        ch_enable[c] = ($urandom_range(0, 3) != 0);
        in_stall[c] = ($urandom_range(0, 9) < 3);
      end
      tick();
      for (int c = 0; c < NC; c++) begin
        if (pv[c] && !in_stall[c]) n[c]++;
        exp_v = (pv[c] && in_stall[c]) || ch_enable[c];
        total++;
        if (out_valid[c] !== exp_v) begin
          bad++;
          $display("FAIL rand_valid cyc=%0d ch=%0d got %b want %b", cyc, c, out_valid[c], exp_v);
        end
        if (exp_v) begin
          total++;
          if (out_address[c*AW +: AW] !== ref_addr(n[c] + 1) || out_id[c*IW +: IW] !== ref_id(c, n[c] + 1)) begin
            bad++;
            $display("FAIL rand_req cyc=%0d ch=%0d got (%h,%h) want (%h,%h)", cyc, c,
                     out_address[c*AW +: AW], out_id[c*IW +: IW], ref_addr(n[c] + 1), ref_id(c, n[c] + 1));
          end
        end
        pv[c] = exp_v;
      end
    end
    ch_enable = '0;
    in_stall = '0;
  endtask

  initial begin
    test_reset();
    test_issue();
    test_stall();
    test_burst();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
